// File: rtl/cacheline_adaptor_pkg.sv
// Shared cacheline/burst constants, beat-index type and adaptor state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cacheline_adaptor_pkg;

  localparam int CL_LINE_WIDTH  = 256;
  localparam int CL_BURST_WIDTH = 64;
  localparam int CL_BEATS       = CL_LINE_WIDTH / CL_BURST_WIDTH;

  // Index of one memory beat within a cacheline.
  typedef logic [$clog2(CL_BEATS)-1:0] beat_idx_t;

  // Adaptor FSM state, visible to arbiter/cache benches.
  typedef enum logic [1:0] {
    CA_IDLE  = 2'd0,
    CA_READ  = 2'd1,
    CA_WRITE = 2'd2,
    CA_DONE  = 2'd3
  } ca_state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Cacheline <-> burst adaptor: one line read/write becomes a BEATS-beat memory burst.
// Latency: accept + gaps + BEATS beats + 1; minimum 5 cycles from acceptance to line_resp_o.
// Backpressure: memory paces beats with burst_resp_i; the arbiter holds its request until line_resp_o.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_WIDTH  = CL_LINE_WIDTH,
  parameter int BURST_WIDTH = CL_BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            line_addr_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic                   line_read_i,
  input  logic                   line_write_i,
  output logic                   line_resp_o,
  output logic [31:0]            burst_addr_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic                   burst_read_o,
  output logic                   burst_write_o,
  input  logic                   burst_resp_i
);

  // LINE_WIDTH/BURST_WIDTH must be a power of two >= 2 so the beat counter wraps cleanly.
  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] ONE_BEAT  = CNT_W'(1);
  // Clears the byte-within-line offset so memory always sees a line-aligned address.
  localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);

  ca_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BEATS-1:0][BURST_WIDTH-1:0] line_buf_q, line_buf_d;
  logic [31:0] addr_q, addr_d;

  // Next-state: accept in IDLE (write wins), step one beat per burst_resp_i, pulse DONE once.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_buf_d = line_buf_q;
    addr_d     = addr_q;
    case (state_q)
      CA_IDLE: begin
        if (line_write_i) begin
          addr_d     = line_addr_i & ADDR_MASK;
          line_buf_d = line_i;
          cnt_d      = '0;
          state_d    = CA_WRITE;
        end else if (line_read_i) begin
          addr_d  = line_addr_i & ADDR_MASK;
          cnt_d   = '0;
          state_d = CA_READ;
        end
      end
      CA_READ: begin
        if (burst_resp_i) begin
          // Little-endian assembly: beat 0 lands in the lowest bits of the line.
          line_buf_d[cnt_q] = burst_i;
          cnt_d             = cnt_q + ONE_BEAT;
          if (cnt_q == LAST_BEAT) begin
            state_d = CA_DONE;
          end
        end
      end
      CA_WRITE: begin
        if (burst_resp_i) begin
          cnt_d = cnt_q + ONE_BEAT;
          if (cnt_q == LAST_BEAT) begin
            state_d = CA_DONE;
          end
        end
      end
      CA_DONE: begin
        // Requests are not sampled here; the arbiter drops them on line_resp_o.
        state_d = CA_IDLE;
      end
      default: begin
        state_d = CA_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-burst simply abandons the transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CA_IDLE;
      cnt_q      <= '0;
      line_buf_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_buf_q <= line_buf_d;
      addr_q     <= addr_d;
    end
  end

  // Outputs are pure decodes of registered state, so none depend combinationally on inputs.
  assign line_resp_o   = (state_q == CA_DONE);
  assign burst_read_o  = (state_q == CA_READ);
  assign burst_write_o = (state_q == CA_WRITE);
  assign burst_addr_o  = addr_q;
  assign line_o        = line_buf_q;
  assign burst_o       = line_buf_q[cnt_q];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: transaction-level model plus directed literals.
// Latency: n/a.
// Backpressure: n/a.
module tb_cacheline_adaptor;

  localparam int LW    = 256;
  localparam int BW    = 64;
  localparam int BEATS = LW / BW;

  logic          clk;
  logic          rst;
  logic [31:0]   line_addr_i;
  logic [LW-1:0] line_i;
  logic [LW-1:0] line_o;
  logic          line_read_i;
  logic          line_write_i;
  logic          line_resp_o;
  logic [31:0]   burst_addr_o;
  logic [BW-1:0] burst_i;
  logic [BW-1:0] burst_o;
  logic          burst_read_o;
  logic          burst_write_o;
  logic          burst_resp_i;

  cacheline_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW)) dut (
    .clk           (clk),
    .rst           (rst),
    .line_addr_i   (line_addr_i),
    .line_i        (line_i),
    .line_o        (line_o),
    .line_read_i   (line_read_i),
    .line_write_i  (line_write_i),
    .line_resp_o   (line_resp_o),
    .burst_addr_o  (burst_addr_o),
    .burst_i       (burst_i),
    .burst_o       (burst_o),
    .burst_read_o  (burst_read_o),
    .burst_write_o (burst_write_o),
    .burst_resp_i  (burst_resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int illegal_cnt = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: what is in flight, how many beats moved, what the line holds.
  int            m_kind;   // 0 none, 1 read, 2 write
  int            m_beats;
  bit            m_resp;
  bit            m_valid = 1'b0;
  logic [LW-1:0] m_line;
  logic [31:0]   m_addr;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_kind  = 0;
      m_beats = 0;
      m_resp  = 1'b0;
      m_line  = '0;
      m_addr  = '0;
    end else if (m_valid) begin
      if (m_resp) begin
        m_resp = 1'b0;
      end else if (m_kind == 0) begin
        if (line_read_i && line_write_i) begin
          illegal_cnt++;
          $display("note: simultaneous line read and write request at %0t", $time);
        end
        if (line_write_i) begin
          m_kind  = 2;
          m_beats = 0;
          m_addr  = {line_addr_i[31:5], 5'd0};
          m_line  = line_i;
        end else if (line_read_i) begin
          m_kind  = 1;
          m_beats = 0;
          m_addr  = {line_addr_i[31:5], 5'd0};
        end
      end else if (burst_resp_i) begin
        if (m_kind == 1) m_line[m_beats*BW +: BW] = burst_i;
        m_beats++;
        if (m_beats == BEATS) begin
          m_kind  = 0;
          m_beats = 0;
          m_resp  = 1'b1;
        end
      end
    end
  end

  // Compare every cycle once reset has been seen, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_line_resp", 256'(line_resp_o), 256'(m_resp));
      chk("cyc_burst_read", 256'(burst_read_o), 256'(m_kind == 1));
      chk("cyc_burst_write", 256'(burst_write_o), 256'(m_kind == 2));
      chk("cyc_burst_addr", 256'(burst_addr_o), 256'(m_addr));
      chk("cyc_line_o", line_o, m_line);
      if (m_kind == 2) chk("cyc_burst_o", 256'(burst_o), 256'(m_line[m_beats*BW +: BW]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one line transaction from IDLE. pat[c] drives burst_resp_i in relative cycle c
  // (cycle 0 is the acceptance cycle, so a bit there is a stray strobe in IDLE).
  task automatic txn(input bit wr, input bit rd, input logic [31:0] addr,
                     input logic [LW-1:0] wl, input logic [3:0][BW-1:0] rb,
                     input logic [15:0] pat, input int plen,
                     output int resp_cyc, output logic [3:0][BW-1:0] wseen);
    int b;
    bit done;
    b = 0;
    done = 1'b0;
    resp_cyc = -1;
    wseen = '0;
    line_write_i = wr;
    line_read_i  = rd;
    line_addr_i  = addr;
    line_i       = wl;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c == 2) begin
        // Request fields change while busy; the latched copies must be used.
        line_addr_i = ~addr;
        line_i      = ~wl;
      end
      burst_resp_i = (c < plen) ? pat[c] : 1'b0;
      burst_i      = 64'hBAD0_BAD0_BAD0_BAD0;
      if (c >= 1 && burst_resp_i) begin
        if (b < 4) begin
          burst_i = rb[b];
          if (wr) wseen[b] = burst_o;
        end
        b++;
      end
      step();
      if (line_resp_o) begin
        done         = 1'b1;
        resp_cyc     = c + 1;
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        burst_resp_i = 1'b0;
      end
    end
    chk("txn_completed", 256'(done), 256'd1);
  endtask

  int                  rc;
  logic [3:0][BW-1:0]  ws;
  logic [3:0][BW-1:0]  rb;
  logic [LW-1:0]       wl;

  initial begin
    rst = 1'b1;
    line_addr_i = '0;
    line_i = '0;
    line_read_i = 1'b0;
    line_write_i = 1'b0;
    burst_i = '0;
    burst_resp_i = 1'b0;
    step();
    step();

    // Reset state.
    chk("rst_line_resp", 256'(line_resp_o), 256'd0);
    chk("rst_burst_read", 256'(burst_read_o), 256'd0);
    chk("rst_burst_write", 256'(burst_write_o), 256'd0);
    chk("rst_line_o", line_o, 256'd0);
    chk("rst_burst_o", 256'(burst_o), 256'd0);
    chk("rst_burst_addr", 256'(burst_addr_o), 256'd0);
    rst = 1'b0;
    step();

    // Read with beats in cycles 3..6.
    rb = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    txn(1'b0, 1'b1, 32'h0000_1234, '0, rb, 16'b0000_0000_0111_1000, 7, rc, ws);
    chk("rd_resp_cycle", 256'(rc), 256'd7);
    chk("rd_addr", 256'(burst_addr_o),  256'h0000_1220);
    chk("rd_line", line_o,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    step();
    chk("rd_resp_single", 256'(line_resp_o), 256'd0);

    // Write with consecutive beats, then a read held high straight out of DONE.
    wl = 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA;
    txn(1'b1, 1'b0, 32'hABCD_EF3F, wl, '0, 16'b0000_0000_0001_1110, 5, rc, ws);
    chk("wr_resp_cycle", 256'(rc), 256'd5);
    chk("wr_beats", 256'(ws), wl);
    chk("wr_write_dropped", 256'(burst_write_o), 256'd0);
    chk("wr_addr", 256'(burst_addr_o), 256'hABCD_EF20);
    line_read_i  = 1'b1;
    line_addr_i  = 32'h0000_4000;
    burst_resp_i = 1'b1;
    burst_i      = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    chk("b2b_idle_no_read", 256'(burst_read_o), 256'd0);
    chk("b2b_idle_no_resp", 256'(line_resp_o), 256'd0);
    rb = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
          64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    txn(1'b0, 1'b1, 32'h0000_4000, '0, rb, 16'b0000_0000_0001_1111, 5, rc, ws);
    chk("b2b_resp_cycle", 256'(rc), 256'd5);
    chk("b2b_line", line_o,
        256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555);
    step();

    // Gapped read: strobes 1,0,0,1,1,0,1 starting in cycle 1.
    rb = {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
          64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A};
    txn(1'b0, 1'b1, 32'h0000_0040, '0, rb, 16'b0000_0000_1011_0010, 8, rc, ws);
    chk("gap_resp_cycle", 256'(rc), 256'd8);
    chk("gap_line", line_o,
        256'h0D0D0D0D0D0D0D0D_0C0C0C0C0C0C0C0C_0B0B0B0B0B0B0B0B_0A0A0A0A0A0A0A0A);
    step();

    // Reset after two read beats aborts without a response.
    line_read_i  = 1'b1;
    line_addr_i  = 32'h0000_8000;
    burst_resp_i = 1'b0;
    step();
    burst_resp_i = 1'b1;
    burst_i      = 64'hFEED_0000_0000_0001;
    step();
    burst_i      = 64'hFEED_0000_0000_0002;
    step();
    rst          = 1'b1;
    burst_resp_i = 1'b0;
    line_read_i  = 1'b0;
    step();
    chk("rstmid_read", 256'(burst_read_o), 256'd0);
    chk("rstmid_resp", 256'(line_resp_o), 256'd0);
    chk("rstmid_line", line_o, 256'd0);
    rst = 1'b0;
    step();
    chk("rstmid_no_late_resp", 256'(line_resp_o), 256'd0);
    rb = {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
          64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};
    txn(1'b0, 1'b1, 32'h0000_9000, '0, rb, 16'b0000_0000_0001_1110, 5, rc, ws);
    chk("rstmid_fresh_line", line_o,
        256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001);
    step();

    // Simultaneous read and write: write is taken, read not serviced.
    wl = 256'h0123456789ABCDEF_FEDCBA9876543210_00FF00FF00FF00FF_F0F0F0F0F0F0F0F0;
    rb = {64'h9999_9999_9999_9999, 64'h9999_9999_9999_9999,
          64'h9999_9999_9999_9999, 64'h9999_9999_9999_9999};
    txn(1'b1, 1'b1, 32'h0000_2000, wl, rb, 16'b0000_0000_0001_1110, 5, rc, ws);
    chk("both_resp_cycle", 256'(rc), 256'd5);
    chk("both_beats", 256'(ws), wl);
    chk("both_line", line_o, wl);
    chk("both_flagged", 256'(illegal_cnt), 256'd1);
    step();
    chk("both_no_read_after", 256'(burst_read_o), 256'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
